// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU front end.
//   - opcode values (byte[7:4] of the first instruction byte)
//   - ALU mode codes, shared with the ALU
//   - decode FSM state codes
//   - writes_rd(): which issued modes write a register back
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_NAND = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_MOV  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BN   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hE;
  localparam logic [3:0] OP_LDI  = 4'hF;

  // ALU mode codes
  localparam logic [3:0] MODE_NOP  = 4'h0;
  localparam logic [3:0] MODE_ADD  = 4'h1;
  localparam logic [3:0] MODE_SUB  = 4'h2;
  localparam logic [3:0] MODE_NAND = 4'h3;
  localparam logic [3:0] MODE_SHL  = 4'h4;
  localparam logic [3:0] MODE_SHR  = 4'h5;
  localparam logic [3:0] MODE_IN   = 4'h7;
  localparam logic [3:0] MODE_MOV  = 4'h8;
  localparam logic [3:0] MODE_OUT  = 4'hE;
  localparam logic [3:0] MODE_LDI  = 4'hF;

  // Decode FSM states
  typedef logic [1:0] state_t;
  localparam state_t S_OP   = 2'd0;
  localparam state_t S_IMM  = 2'd1;
  localparam state_t S_HALT = 2'd2;

  // Modes whose ALU result is written back to R[rd].
  function automatic logic writes_rd(input logic [3:0] m);
    case (m)
      MODE_ADD, MODE_SUB, MODE_NAND, MODE_SHL, MODE_SHR,
      MODE_IN, MODE_MOV, MODE_LDI: writes_rd = 1'b1;
      default:                     writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: 4 x 8-bit register file.
//   clk, rst          : clock, synchronous active-high reset (clears all regs)
//   we, waddr, wdata  : synchronous write port
//   raddr_a, rdata_a  : asynchronous read port A
//   raddr_b, rdata_b  : asynchronous read port B
// Reads return the stored value; any same-cycle bypass is done by the user.
module reg_file (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [1:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] regs [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch / decode / operand-issue stage of the 8-bit CPU.
//   clk, rst    : clock, synchronous active-high reset
//   imem_addr   : instruction ROM address (= pc, combinational)
//   imem_data   : ROM byte at imem_addr, same cycle
//   in_port     : external input consumed by IN
//   alu_result  : ALU result for the instruction currently in EX
//   zn          : ALU flags, zn[1] = Z, zn[0] = N
//   mode        : registered ALU operation code
//   s1, s2, imm : registered ALU operands
//   ex_in       : registered copy of in_port for IN
//   out_port    : output register written by OUT
//   halt        : set once HALT has executed, cleared only by rst
//   dbg_state   : current decode FSM state (S_OP / S_IMM / S_HALT)
module decode_stage
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  input  logic [7:0]      in_port,
  input  logic [7:0]      alu_result,
  input  logic [1:0]      zn,
  output logic [3:0]      mode,
  output logic [7:0]      s1,
  output logic [7:0]      s2,
  output logic [7:0]      imm,
  output logic [7:0]      ex_in,
  output logic [7:0]      out_port,
  output logic            halt,
  output logic [1:0]      dbg_state
);

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n, pc_inc, pc_target;

  // Instruction in EX: drives writeback at the next posedge.
  logic            wb_en_q;
  logic [1:0]      rd_q;

  // First byte of a 2-byte instruction, held across S_IMM.
  logic [3:0]      pend_op;
  logic [1:0]      pend_rd;

  logic [3:0]      op;
  logic [1:0]      ra, rb;
  logic [7:0]      rf_a, rf_b, opnd_a, opnd_b;

  logic [3:0]      issue_mode;
  logic [1:0]      issue_rd;
  logic            load_imm, load_ex, set_halt, pend_load;

  assign op        = imem_data[7:4];
  assign ra        = imem_data[3:2];
  assign rb        = imem_data[1:0];
  assign imem_addr = pc;
  assign dbg_state = state;
  assign pc_inc    = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_target = PC_W'(imem_data);

  reg_file u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en_q),
    .waddr   (rd_q),
    .wdata   (alu_result),
    .raddr_a (ra),
    .rdata_a (rf_a),
    .raddr_b (rb),
    .rdata_b (rf_b)
  );

  // The EX result is written back at the same posedge that issues the
  // next instruction, so its operands bypass the register file.
  assign opnd_a = (wb_en_q && (rd_q == ra)) ? alu_result : rf_a;
  assign opnd_b = (wb_en_q && (rd_q == rb)) ? alu_result : rf_b;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    issue_mode = MODE_NOP;
    issue_rd   = ra;
    load_imm   = 1'b0;
    load_ex    = 1'b0;
    set_halt   = 1'b0;
    pend_load  = 1'b0;
    case (state)
      S_OP: begin
        pc_n = pc_inc;
        case (op)
          OP_LDI, OP_BZ, OP_BN, OP_JMP: begin
            // Bubble now; the real issue happens once byte2 is fetched.
            pend_load = 1'b1;
            state_n   = S_IMM;
          end
          OP_HALT: begin
            pc_n     = pc;
            set_halt = 1'b1;
            state_n  = S_HALT;
          end
          OP_ADD:  issue_mode = MODE_ADD;
          OP_SUB:  issue_mode = MODE_SUB;
          OP_NAND: issue_mode = MODE_NAND;
          OP_SHL:  issue_mode = MODE_SHL;
          OP_SHR:  issue_mode = MODE_SHR;
          OP_MOV:  issue_mode = MODE_MOV;
          OP_OUT:  issue_mode = MODE_OUT;
          OP_IN: begin
            issue_mode = MODE_IN;
            load_ex    = 1'b1;
          end
          default: issue_mode = MODE_NOP;  // NOP and reserved 6, D
        endcase
      end
      S_IMM: begin
        state_n  = S_OP;
        issue_rd = pend_rd;
        pc_n     = pc_inc;
        case (pend_op)
          OP_LDI: begin
            issue_mode = MODE_LDI;
            load_imm   = 1'b1;
          end
          OP_JMP:  pc_n = pc_target;
          OP_BZ:   if (zn[1]) pc_n = pc_target;
          OP_BN:   if (zn[0]) pc_n = pc_target;
          default: pc_n = pc_inc;
        endcase
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_OP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OP;
      pc       <= '0;
      mode     <= MODE_NOP;
      s1       <= 8'h00;
      s2       <= 8'h00;
      imm      <= 8'h00;
      ex_in    <= 8'h00;
      out_port <= 8'h00;
      halt     <= 1'b0;
      wb_en_q  <= 1'b0;
      rd_q     <= 2'd0;
      pend_op  <= OP_NOP;
      pend_rd  <= 2'd0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      mode    <= issue_mode;
      s1      <= opnd_a;
      s2      <= opnd_b;
      wb_en_q <= writes_rd(issue_mode);
      rd_q    <= issue_rd;
      if (load_imm)  imm   <= imem_data;
      if (load_ex)   ex_in <= in_port;
      if (set_halt)  halt  <= 1'b1;
      if (pend_load) begin
        pend_op <= op;
        pend_rd <= ra;
      end
      // OUT passes R[ra] through the ALU; capture it as it leaves EX.
      if (mode == MODE_OUT) out_port <= alu_result;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_addr, imem_data, in_port, alu_result;
  logic [1:0] zn;
  logic [3:0] mode;
  logic [7:0] s1, s2, imm, ex_in, out_port;
  logic       halt;
  logic [1:0] dbg_state;

  logic [7:0] rom [256];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage #(.PC_W(8)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .in_port(in_port), .alu_result(alu_result), .zn(zn), .mode(mode),
    .s1(s1), .s2(s2), .imm(imm), .ex_in(ex_in), .out_port(out_port),
    .halt(halt), .dbg_state(dbg_state)
  );

  // Asynchronous ROM.
  assign imem_data = rom[imem_addr];

  // Behavioural ALU stand-in: result of whatever is in EX.
  function automatic logic [7:0] alu_f(input logic [3:0] m, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] i,
                                       input logic [7:0] x);
    case (m)
      4'h1:    alu_f = a + b;
      4'h2:    alu_f = a - b;
      4'h3:    alu_f = ~(a & b);
      4'h4:    alu_f = a << 1;
      4'h5:    alu_f = a >> 1;
      4'h7:    alu_f = x;
      4'h8:    alu_f = b;
      4'hE:    alu_f = a;
      4'hF:    alu_f = i;
      default: alu_f = 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(mode, s1, s2, imm, ex_in);

  // Inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic test_reset();
    rom_clear();
    zn = 2'b00;
    in_port = 8'h00;
    do_reset();
    n_checks++;
    if ({imem_addr, mode, s1, s2, imm, ex_in, out_port, halt, dbg_state} !==
        {8'h00, 4'h0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, S_OP}) begin
      n_fail++;
      $display("FAIL reset: pc=%h mode=%h s1=%h s2=%h imm=%h ex_in=%h out=%h halt=%b st=%0d, want all 0, S_OP",
               imem_addr, mode, s1, s2, imm, ex_in, out_port, halt, dbg_state);
    end
  endtask

  task automatic test_program();
    rom_clear();
    rom[0] = 8'hF4; rom[1] = 8'h05; rom[2] = 8'hF8; rom[3] = 8'h03;
    rom[4] = 8'h16; rom[5] = 8'hE4;
    do_reset();
    tick();
    n_checks++;
    if ({mode, imem_addr, dbg_state} !== {4'h0, 8'h01, S_IMM}) begin
      n_fail++;
      $display("FAIL ldi1_bubble: mode=%h pc=%h st=%0d, want 0 01 S_IMM", mode, imem_addr, dbg_state);
    end
    tick();
    n_checks++;
    if ({mode, imm, imem_addr} !== {4'hF, 8'h05, 8'h02}) begin
      n_fail++;
      $display("FAIL ldi1_issue: mode=%h imm=%h pc=%h, want F 05 02", mode, imm, imem_addr);
    end
    tick();
    tick();
    n_checks++;
    if ({mode, imm, imem_addr} !== {4'hF, 8'h03, 8'h04}) begin
      n_fail++;
      $display("FAIL ldi2_issue: mode=%h imm=%h pc=%h, want F 03 04", mode, imm, imem_addr);
    end
    tick();
    n_checks++;
    if ({mode, s1, s2, imm} !== {4'h1, 8'h05, 8'h03, 8'h03}) begin
      n_fail++;
      $display("FAIL add_issue: mode=%h s1=%h s2=%h imm=%h, want 1 05 03 03", mode, s1, s2, imm);
    end
    tick();
    n_checks++;
    if ({mode, s1} !== {4'hE, 8'h08}) begin
      n_fail++;
      $display("FAIL out_fwd: mode=%h s1=%h, want E 08", mode, s1);
    end
    tick();
    n_checks++;
    if (out_port !== 8'h08) begin
      n_fail++;
      $display("FAIL out_port: got %h want 08", out_port);
    end
  endtask

  task automatic test_branch();
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] want_pc;
      rom_clear();
      rom[8'h10] = 8'h90; rom[8'h11] = 8'h20;
      zn = (pass == 0) ? 2'b10 : 2'b00;
      want_pc = (pass == 0) ? 8'h20 : 8'h12;
      do_reset();
      for (int i = 0; i < 16; i++) tick();
      tick();
      n_checks++;
      if ({mode, imem_addr, dbg_state} !== {4'h0, 8'h11, S_IMM}) begin
        n_fail++;
        $display("FAIL bz_bubble[%0d]: mode=%h pc=%h st=%0d, want 0 11 S_IMM", pass, mode, imem_addr, dbg_state);
      end
      tick();
      n_checks++;
      if ({mode, imem_addr} !== {4'h0, want_pc}) begin
        n_fail++;
        $display("FAIL bz_resolve[%0d]: mode=%h pc=%h, want 0 %h", pass, mode, imem_addr, want_pc);
      end
    end
  endtask

  task automatic test_jmp_wrap();
    rom_clear();
    rom[8'hFF] = 8'hB0; rom[8'h00] = 8'h40;
    zn = 2'b00;
    do_reset();
    for (int i = 0; i < 255; i++) tick();
    n_checks++;
    if (imem_addr !== 8'hFF) begin
      n_fail++;
      $display("FAIL jmp_reach_ff: pc=%h want ff", imem_addr);
    end
    tick();
    n_checks++;
    if ({imem_addr, dbg_state} !== {8'h00, S_IMM}) begin
      n_fail++;
      $display("FAIL jmp_wrap_fetch: pc=%h st=%0d, want 00 S_IMM", imem_addr, dbg_state);
    end
    tick();
    n_checks++;
    if ({mode, imem_addr} !== {4'h0, 8'h40}) begin
      n_fail++;
      $display("FAIL jmp_target: mode=%h pc=%h, want 0 40", mode, imem_addr);
    end
  endtask

  task automatic test_reset_mid_ldi();
    rom_clear();
    rom[0] = 8'hF4; rom[1] = 8'h77;
    do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({dbg_state, imem_addr, mode} !== {S_OP, 8'h00, 4'h0}) begin
      n_fail++;
      $display("FAIL mid_ldi_reset: st=%0d pc=%h mode=%h, want S_OP 00 0", dbg_state, imem_addr, mode);
    end
    rom[0] = 8'hE4;  // OUT R1 exposes R1
    tick();
    n_checks++;
    if ({mode, s1} !== {4'hE, 8'h00}) begin
      n_fail++;
      $display("FAIL mid_ldi_r1: mode=%h s1=%h, want E 00", mode, s1);
    end
  endtask

  task automatic test_halt();
    rom_clear();
    rom[0] = 8'hC0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({halt, imem_addr, mode, dbg_state} !== {1'b1, 8'h00, 4'h0, S_HALT}) begin
        n_fail++;
        $display("FAIL halt[%0d]: halt=%b pc=%h mode=%h st=%0d, want 1 00 0 S_HALT", i, halt, imem_addr, mode, dbg_state);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({halt, dbg_state} !== {1'b0, S_OP}) begin
      n_fail++;
      $display("FAIL halt_exit: halt=%b st=%0d, want 0 S_OP", halt, dbg_state);
    end
  endtask

  // Random program checked against an instruction-level model of the CPU.
  task automatic test_random();
    logic [7:0] r_m [4];
    logic [7:0] pc_m, out_m, b, b2;
    logic [3:0] op, want_mode;
    logic [1:0] ra, rb;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hC) b[7:4] = 4'h0;  // keep the program running
      rom[i] = b;
    end
    do_reset();
    for (int i = 0; i < 4; i++) r_m[i] = 8'h00;
    pc_m  = 8'h00;
    out_m = 8'h00;
    for (int k = 0; k < 300; k++) begin
      b  = rom[pc_m];
      op = b[7:4];
      ra = b[3:2];
      rb = b[1:0];
      zn = 2'($urandom_range(0, 3));
      in_port = 8'($urandom);
      if (op == 4'hF || op == 4'h9 || op == 4'hA || op == 4'hB) begin
        b2 = rom[8'(pc_m + 8'd1)];
        tick();
        n_checks++;
        if ({mode, imem_addr, out_port} !== {4'h0, 8'(pc_m + 8'd1), out_m}) begin
          n_fail++;
          $display("FAIL rnd_bubble[%0d]: mode=%h pc=%h out=%h, want 0 %h %h", k, mode, imem_addr, out_port, 8'(pc_m + 8'd1), out_m);
        end
        tick();
        if (op == 4'hF) begin
          r_m[ra] = b2;
          pc_m    = pc_m + 8'd2;
          n_checks++;
          if ({mode, imm, imem_addr} !== {4'hF, b2, pc_m}) begin
            n_fail++;
            $display("FAIL rnd_ldi[%0d]: mode=%h imm=%h pc=%h, want F %h %h", k, mode, imm, imem_addr, b2, pc_m);
          end
        end else begin
          if (op == 4'hB || (op == 4'h9 && zn[1]) || (op == 4'hA && zn[0])) pc_m = b2;
          else pc_m = pc_m + 8'd2;
          n_checks++;
          if ({mode, imem_addr} !== {4'h0, pc_m}) begin
            n_fail++;
            $display("FAIL rnd_branch[%0d]: op=%h zn=%b mode=%h pc=%h, want 0 %h", k, op, zn, mode, imem_addr, pc_m);
          end
        end
      end else begin
        case (op)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'h8, 4'hE: want_mode = op;
          default: want_mode = 4'h0;
        endcase
        tick();
        n_checks++;
        if ({mode, imem_addr, out_port} !== {want_mode, 8'(pc_m + 8'd1), out_m}) begin
          n_fail++;
          $display("FAIL rnd_issue[%0d]: op=%h mode=%h pc=%h out=%h, want %h %h %h", k, op, mode, imem_addr, out_port, want_mode, 8'(pc_m + 8'd1), out_m);
        end
        if (want_mode != 4'h0) begin
          n_checks++;
          if ({s1, s2} !== {r_m[ra], r_m[rb]}) begin
            n_fail++;
            $display("FAIL rnd_operands[%0d]: s1=%h s2=%h, want %h %h", k, s1, s2, r_m[ra], r_m[rb]);
          end
        end
        if (op == 4'h7) begin
          n_checks++;
          if (ex_in !== in_port) begin
            n_fail++;
            $display("FAIL rnd_ex_in[%0d]: got %h want %h", k, ex_in, in_port);
          end
        end
        case (op)
          4'h1: r_m[ra] = r_m[ra] + r_m[rb];
          4'h2: r_m[ra] = r_m[ra] - r_m[rb];
          4'h3: r_m[ra] = ~(r_m[ra] & r_m[rb]);
          4'h4: r_m[ra] = {r_m[ra][6:0], 1'b0};
          4'h5: r_m[ra] = {1'b0, r_m[ra][7:1]};
          4'h7: r_m[ra] = in_port;
          4'h8: r_m[ra] = r_m[rb];
          4'hE: out_m   = r_m[ra];
          default: ;
        endcase
        pc_m = pc_m + 8'd1;
      end
    end
  endtask

  initial begin
    rom_clear();
    zn = 2'b00;
    in_port = 8'h00;
    test_reset();
    test_program();
    test_branch();
    test_jmp_wrap();
    test_reset_mid_ldi();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Fetch/decode/operand-issue stage of the 8-bit CPU, directly upstream of the ALU. Each cycle it:
- fetches from an asynchronous instruction ROM;
- decodes 1- and 2-byte instructions with a small FSM;
- reads the 4×8 register file, with forwarding of the in-flight ALU result;
- drives registered `mode`, `s1`, `s2`, `imm` and `ex_in` to the ALU.

It also owns the PC, branch resolution from the ALU `ZN` flags, register writeback and the output port.

## Interface
- `PC_W`, 8: PC and instruction-address width.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out PC_W: equals `pc` (combinational).
- `imem_data` in 8: ROM byte at `imem_addr`, valid in the same cycle.
- `in_port` in 8: external input, consumed by IN.
- `alu_result` in 8: ALU combinational result for the instruction currently issued.
- `zn` in 2: ALU flags; `zn[1]` = Z, `zn[0]` = N, used as delivered.
- `mode` out 4: ALU operation code.
- `s1`, `s2`, `imm`, `ex_in` out 8: registered ALU operands.
- `out_port` out 8: register written by OUT.
- `halt` out 1: high once HALT has executed.

## Operation
Encoding: `op` = byte[7:4], `rd`/`ra` = byte[3:2], `rb` = byte[1:0].

Instructions and the `mode` each issues:
- 0 NOP → mode 0.
- 1 ADD, 2 SUB, 3 NAND: `rd <= ra op rb` → mode 1/2/3.
- 4 SHL, 5 SHR: `rd <= shift(ra)` → mode 4/5.
- 7 IN: `rd <= in_port` → mode 7, with `ex_in <= in_port`.
- 8 MOV: `rd <= rb` → mode 8.
- E OUT: `out_port <= ra` → mode E, no register write.
- F LDI (2 bytes): `rd <= byte2` → mode F.
- 9 BZ, A BN, B JMP (2 bytes, byte2 = target) → mode 0.
- C HALT → mode 0.
- 6, D are reserved and execute as NOP.

Issue and writeback:
- `s1 <= R[ra]`, `s2 <= R[rb]`. On non-LDI issues, `imm` holds its previous value.
- Issue register `wb_en_q`/`rd_q` tracks the instruction in EX. Set for modes 1–5, 7, 8, F.
- At the next posedge, `R[rd_q] <= alu_result` when `wb_en_q`; `out_port <= alu_result` when the issued mode was E.
- Forwarding: when `wb_en_q` and `rd_q` equals `ra` or `rb`, that operand takes `alu_result` instead of the register-file value.

FSM states S_OP, S_IMM, S_HALT:
- **S_OP**, 1-byte op: issue it, `pc <= pc+1`.
- **S_OP**, op F/9/A/B: latch op and `rd`, issue NOP, `pc <= pc+1`, go to S_IMM.
- **S_OP**, op C: issue NOP, set `halt`, go to S_HALT; `pc` is unchanged.
- **S_IMM**, LDI: issue mode F with `imm <= imem_data`, `pc <= pc+1`.
- **S_IMM**, branches: issue NOP. `pc <= imem_data` if JMP, BZ with `zn[1]`, or BN with `zn[0]`; otherwise `pc <= pc+1`. Go to S_OP.
- **S_HALT**: issue NOP every cycle; leave only on `rst`.

## Timing
- Reset values:
  - `pc`, `mode`, `s1`, `s2`, `imm`, `ex_in`, `out_port`, all R[0..3]: 0.
  - `halt`, `wb_en_q`: 0.
  - State: S_OP.
- Reset has priority over every event, including mid-S_IMM: the partial instruction is dropped and nothing is issued or written.
- 1-byte instruction: issued one posedge after fetch. Writeback lands at the following posedge and is visible to the next decode via forwarding.
- 2-byte instruction: 2 cycles, with a bubble first.
- Branches and JMP: 2 cycles, no further penalty. The target is fetched in the cycle after S_IMM.
- Branch flags are sampled in the S_IMM cycle. The EX slot holds the bubble then, so `zn` reflects the instruction issued before the branch.
- `pc` wraps 0xFF → 0x00. A 2-byte instruction at 0xFF reads its byte2 from 0x00.
- Writeback and a register-file read of the same register in the same cycle: the forwarded value wins.

## Structure
- `cpu_pkg` holds the opcode localparams, ALU mode codes (shared with the ALU) and the FSM state enum.
- One sub-module, `reg_file`: 4×8, two asynchronous read ports, one synchronous write port, synchronous reset to zero.

## Test plan
- Reset: hold `rst` for 2 cycles → `pc`=0, `mode`=0, `s1`/`s2`/`imm`/`out_port`=0, `halt`=0.
- Program F4 05, F8 03, 16, E4:
  - EX sees mode F with `imm`=05, then mode F with `imm`=03.
  - ADD issues mode 1 with `s1`=05, `s2`=03.
  - OUT issues mode E with `s1`=08 (forwarded); `out_port`=08 one cycle later.
- BZ: 90 20 at 0x10.
  - `zn`=2'b10 → `pc`=0x20, two NOPs issued.
  - `zn`=2'b00 → `pc`=0x12.
- JMP wrap: B0 at 0xFF, 40 at 0x00 → `pc`=0x40.
- Reset mid-LDI: F4 fetched, `rst` asserted in S_IMM → next cycle S_OP, `pc`=0, R1 unchanged (0).
- HALT: C0 → `halt`=1, `pc` frozen, `mode`=0 every cycle until `rst`.
